// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data RAM plus a memory-mapped
// timer/LED/7-seg/systick bank. Loads are combinational; stores and timer updates land on the edge.
module mem_access_stage #(
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        irq_o,
  output logic [7:0]  led_o,
  output logic [11:0] digi_o
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // Peripheral word offsets from PERIPH_BASE
  localparam logic [2:0] P_TH      = 3'd0;
  localparam logic [2:0] P_TL      = 3'd1;
  localparam logic [2:0] P_TCON    = 3'd2;
  localparam logic [2:0] P_LED     = 3'd3;
  localparam logic [2:0] P_DIGI    = 3'd4;
  localparam logic [2:0] P_SYSTICK = 3'd5;
  localparam int unsigned NPER     = 6;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  mem_req_t          req;
  logic              ram_hit;
  logic              per_hit;
  logic [29:0]       off_w;
  logic [AW-1:0]     ram_idx;
  logic [NPER-1:0]   per_wr;

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;
  logic        ovf;

  assign req = '{rd: MemRead_i, wr: MemWrite_i, addr: Addr_i, wdata: WriteData_i};

  // RAM decode takes priority so a low PERIPH_BASE can never shadow RAM words.
  assign ram_hit = req.addr < RAM_BYTES;
  assign ram_idx = req.addr[AW+1:2];
  assign off_w   = req.addr[31:2] - PERIPH_BASE[31:2];
  assign per_hit = !ram_hit && (off_w < 30'(NPER));

  always_comb begin
    per_wr = '0;
    for (int i = 0; i < NPER; i++)
      per_wr[i] = req.wr && per_hit && (off_w[2:0] == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (req.wr && ram_hit)
      ram_q[ram_idx] <= req.wdata;
  end

  // A CPU write to TL or TCON on the overflow edge suppresses both the reload and the status set.
  always_comb begin
    ovf       = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    th_d      = per_wr[P_TH] ? req.wdata : th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = per_wr[P_LED]  ? req.wdata[7:0]  : led_q;
    digi_d    = per_wr[P_DIGI] ? req.wdata[11:0] : digi_q;
    systick_d = systick_q + 32'd1;

    if (per_wr[P_TL])
      tl_d = req.wdata;
    else if (ovf) begin
      if (!per_wr[P_TCON])
        tl_d = th_q;
    end else if (tcon_q[0])
      tl_d = tl_q + 32'd1;

    if (per_wr[P_TCON])
      tcon_d = req.wdata[2:0];
    else if (ovf && !per_wr[P_TL] && tcon_q[1])
      tcon_d[2] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    ReadData_o = 32'h0;
    if (req.rd) begin
      if (ram_hit)
        ReadData_o = ram_q[ram_idx];
      else if (per_hit) begin
        case (off_w[2:0])
          P_TH:      ReadData_o = th_q;
          P_TL:      ReadData_o = tl_q;
          P_TCON:    ReadData_o = {29'b0, tcon_q};
          P_LED:     ReadData_o = {24'b0, led_q};
          P_DIGI:    ReadData_o = {20'b0, digi_q};
          P_SYSTICK: ReadData_o = systick_q;
          default:   ReadData_o = 32'h0;
        endcase
      end
    end
  end

  assign irq_o  = tcon_q[2];
  assign led_o  = led_q;
  assign digi_o = digi_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: RAM, timer overflow and collisions, peripherals, async reset.
module tb_mem_access_stage;

  localparam logic [31:0] PB = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        irq_o;
  logic [7:0]  led_o;
  logic [11:0] digi_o;

  int errors = 0;
  int checks = 0;
  int unsigned n_edges;

  mem_access_stage #(.RAM_WORDS(256), .PERIPH_BASE(PB)) dut (
    .clk(clk), .reset(reset), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Addr_i(Addr_i), .WriteData_i(WriteData_i), .ReadData_o(ReadData_o),
    .irq_o(irq_o), .led_o(led_o), .digi_o(digi_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges seen since reset release: the expected SYSTICK value.
  always @(posedge clk or negedge reset) begin
    if (!reset) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr_i = a; WriteData_i = d; MemWrite_i = 1'b1; MemRead_i = 1'b0;
    @(posedge clk); #1;
    MemWrite_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    Addr_i = a; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    #1;
  endtask

  task automatic tick;
    MemRead_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq_o); end
    checks++; if (led_o !== 8'h0) begin errors++; $display("FAIL rst_led: got %h exp 00", led_o); end
    checks++; if (digi_o !== 12'h0) begin errors++; $display("FAIL rst_digi: got %h exp 000", digi_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL rst_tl: got %h exp 0", ReadData_o); end
    rd(PB + 32'h8);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL rst_tcon: got %h exp 0", ReadData_o); end
    MemRead_i = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_ram;
    wr(32'h0, 32'h1111_1111);
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    checks++; if (ReadData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd10: got %h exp deadbeef", ReadData_o); end
    rd(32'h13);
    checks++; if (ReadData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd13: got %h exp deadbeef", ReadData_o); end
    rd(32'h0);
    checks++; if (ReadData_o !== 32'h1111_1111) begin errors++; $display("FAIL ram_rd0: got %h exp 11111111", ReadData_o); end
    // Load and store together: old value visible, new one stored.
    Addr_i = 32'h10; WriteData_i = 32'h1234_5678; MemRead_i = 1'b1; MemWrite_i = 1'b1;
    #1;
    checks++; if (ReadData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rdw_old: got %h exp deadbeef", ReadData_o); end
    @(posedge clk); #1;
    MemWrite_i = 1'b0;
    rd(32'h10);
    checks++; if (ReadData_o !== 32'h1234_5678) begin errors++; $display("FAIL ram_rdw_new: got %h exp 12345678", ReadData_o); end
    wr(32'h3FC, 32'hCAFE_F00D);
    rd(32'h3FC);
    checks++; if (ReadData_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_last: got %h exp cafef00d", ReadData_o); end
    wr(32'h400, 32'hBAD0_BAD0);
    rd(32'h0);
    checks++; if (ReadData_o !== 32'h1111_1111) begin errors++; $display("FAIL ram_noalias: got %h exp 11111111", ReadData_o); end
    rd(32'h400);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL ram_oob: got %h exp 0", ReadData_o); end
  endtask

  task automatic test_timer;
    wr(PB, 32'hFFFF_FFFC);
    wr(PB + 32'h4, 32'hFFFF_FFFE);
    wr(PB + 32'h8, 32'h3);
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tmr_tl0: got %h exp fffffffe", ReadData_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL tmr_irq0: got %b exp 0", irq_o); end
    tick;
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmr_tl1: got %h exp ffffffff", ReadData_o); end
    tick;
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL tmr_reload: got %h exp fffffffc", ReadData_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL tmr_irq1: got %b exp 1", irq_o); end
    rd(PB + 32'h8);
    checks++; if (ReadData_o !== 32'h7) begin errors++; $display("FAIL tmr_tcon7: got %h exp 7", ReadData_o); end
    wr(PB + 32'h8, 32'h3);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL tmr_irqclr: got %b exp 0", irq_o); end
    rd(PB + 32'h8);
    checks++; if (ReadData_o !== 32'h3) begin errors++; $display("FAIL tmr_tcon3: got %h exp 3", ReadData_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL tmr_tl2: got %h exp fffffffd", ReadData_o); end
  endtask

  task automatic test_collision;
    wr(PB + 32'h8, 32'h0);
    wr(PB + 32'h4, 32'hFFFF_FFFF);
    wr(PB, 32'h5);
    wr(PB + 32'h8, 32'h3);
    wr(PB + 32'h8, 32'h1);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL col_irq: got %b exp 0", irq_o); end
    rd(PB + 32'h8);
    checks++; if (ReadData_o !== 32'h1) begin errors++; $display("FAIL col_tcon: got %h exp 1", ReadData_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL col_tlhold: got %h exp ffffffff", ReadData_o); end
    tick;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL col_irq2: got %b exp 0", irq_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'h5) begin errors++; $display("FAIL col_reload: got %h exp 5", ReadData_o); end
    wr(PB + 32'h4, 32'hFFFF_FFFF);
    wr(PB, 32'h9);
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'h5) begin errors++; $display("FAIL col_th_oldtl: got %h exp 5", ReadData_o); end
    rd(PB);
    checks++; if (ReadData_o !== 32'h9) begin errors++; $display("FAIL col_th_new: got %h exp 9", ReadData_o); end
    wr(PB + 32'h8, 32'h3);
    wr(PB + 32'h4, 32'hFFFF_FFFF);
    wr(PB + 32'h4, 32'h100);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL col_tl_irq: got %b exp 0", irq_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'h100) begin errors++; $display("FAIL col_tl_wins: got %h exp 100", ReadData_o); end
    wr(PB + 32'h8, 32'h0);
  endtask

  task automatic test_periph;
    wr(PB + 32'h8, 32'hFFFF_FFF2);
    rd(PB + 32'h8);
    checks++; if (ReadData_o !== 32'h2) begin errors++; $display("FAIL per_tcon_mask: got %h exp 2", ReadData_o); end
    wr(PB + 32'h8, 32'h0);
    wr(PB + 32'hC, 32'h1A5);
    checks++; if (led_o !== 8'hA5) begin errors++; $display("FAIL per_led: got %h exp a5", led_o); end
    rd(PB + 32'hC);
    checks++; if (ReadData_o !== 32'hA5) begin errors++; $display("FAIL per_led_rd: got %h exp a5", ReadData_o); end
    wr(PB + 32'h10, 32'hF3F);
    checks++; if (digi_o !== 12'hF3F) begin errors++; $display("FAIL per_digi: got %h exp f3f", digi_o); end
    rd(PB + 32'h10);
    checks++; if (ReadData_o !== 32'hF3F) begin errors++; $display("FAIL per_digi_rd: got %h exp f3f", ReadData_o); end
    wr(PB + 32'h14, 32'h1234_5678);
    rd(PB + 32'h14);
    checks++; if (ReadData_o !== n_edges) begin errors++; $display("FAIL per_systick_ro: got %h exp %h", ReadData_o, n_edges); end
    tick;
    rd(PB + 32'h14);
    checks++; if (ReadData_o !== n_edges) begin errors++; $display("FAIL per_systick_cnt: got %h exp %h", ReadData_o, n_edges); end
    rd(32'h2000_0000);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL per_unmapped: got %h exp 0", ReadData_o); end
    rd(PB + 32'h18);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL per_past_end: got %h exp 0", ReadData_o); end
    Addr_i = PB + 32'hC; MemRead_i = 1'b0;
    #1;
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL per_noread: got %h exp 0", ReadData_o); end
  endtask

  task automatic test_async_reset;
    wr(PB, 32'h0);
    wr(PB + 32'h4, 32'hFFFF_FFFF);
    wr(PB + 32'h8, 32'h3);
    tick;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL ar_irq_pre: got %b exp 1", irq_o); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b exp 0", irq_o); end
    checks++; if (led_o !== 8'h0) begin errors++; $display("FAIL ar_led: got %h exp 00", led_o); end
    checks++; if (digi_o !== 12'h0) begin errors++; $display("FAIL ar_digi: got %h exp 000", digi_o); end
    rd(PB + 32'h4);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL ar_tl: got %h exp 0", ReadData_o); end
    reset = 1'b1;
    rd(PB + 32'h14);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL ar_systick0: got %h exp 0", ReadData_o); end
    tick;
    rd(PB + 32'h14);
    checks++; if (ReadData_o !== 32'h1) begin errors++; $display("FAIL ar_systick1: got %h exp 1", ReadData_o); end
    rd(32'h10);
    checks++; if (ReadData_o !== 32'h1234_5678) begin errors++; $display("FAIL ar_ram10: got %h exp 12345678", ReadData_o); end
    rd(32'h3FC);
    checks++; if (ReadData_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL ar_ram3fc: got %h exp cafef00d", ReadData_o); end
    MemRead_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Addr_i = 32'h0; WriteData_i = 32'h0;
    test_reset;
    test_ram;
    test_timer;
    test_collision;
    test_periph;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Holds the word-addressed data RAM and a memory-mapped peripheral bank: timer, LEDs, 7-seg digits and systick.
- ReadData_o is combinational from the current address, so the MEM/WB register captures it at the end of the same cycle.
- The timer raises irq_o toward the ID-stage interrupt logic.

Parameters:
- RAM_WORDS, 256, number of 32-bit data RAM words; must be a power of 2.
- PERIPH_BASE, 32'h4000_0000, base address of the peripheral bank.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- MemRead_i  input  1  load in MEM stage this cycle.
- MemWrite_i  input  1  store in MEM stage this cycle.
- Addr_i  input  32  byte address (ALU result); bits [1:0] are ignored.
- WriteData_i  input  32  store data.
- ReadData_o  output  32  load data, combinational.
- irq_o  output  1  timer interrupt request, level.
- led_o  output  8  LED register.
- digi_o  output  12  7-seg register: [11:8] anode select, [7:0] segments.

Behaviour:
- Reset asserted (reset=0), any time including mid-operation:
  - TH, TL, TCON, LED, DIGI and SYSTICK clear to 0 immediately.
  - irq_o=0, led_o=0, digi_o=0.
  - RAM contents are not reset.
- Address decode uses word index w = Addr_i[31:2].
  - RAM: Addr_i < RAM_WORDS*4 selects RAM[Addr_i[log2(RAM_WORDS)+1:2]].
  - Peripherals, by offset from PERIPH_BASE:
    - +0x00 TH, R/W.
    - +0x04 TL, R/W.
    - +0x08 TCON[2:0], R/W, upper bits read 0.
    - +0x0C LED[7:0], R/W.
    - +0x10 DIGI[11:0], R/W.
    - +0x14 SYSTICK, read-only; writes ignored.
  - Any other address: reads return 0, writes are ignored.
- Read path:
  - ReadData_o = decoded value when MemRead_i=1, else 32'h0.
  - Zero latency. A read returns the pre-edge value of the location, including SYSTICK and TL.
- Write path:
  - On a rising edge with MemWrite_i=1, the addressed location takes WriteData_i (truncated to register width).
  - If MemRead_i and MemWrite_i are both 1: the write is performed and ReadData_o shows the old value.
- TCON bits:
  - [0] enable.
  - [1] irq enable.
  - [2] irq status.
- irq_o = TCON[2].
- Timer, each edge with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 if TCON[1]=1.
  - Otherwise TL <= TL+1.
  - With TCON[0]=0, TL holds.
- SYSTICK increments every edge, wrapping from 32'hFFFF_FFFF to 0.
- Simultaneous events:
  - A CPU write to TL or TCON in the same cycle as an overflow wins entirely. The written value is stored, with no reload and no status set.
  - Software clears the IRQ by writing TCON with bit 2 = 0.
  - A write to TH during overflow: TL reloads the old TH, and TH takes the new value.
- No stalls: the stage completes every access in one cycle.

Test Plan:
- RAM write/read:
  - Store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> ReadData_o=32'hDEADBEEF in the load's cycle.
  - Load 0x0000_0013 -> same word.
- Timer overflow:
  - Write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3.
  - -> TL reads FFFF_FFFF after 1 edge.
  - -> After 2 edges, TL=FFFF_FFFC and irq_o=1.
  - Write TCON=3 -> irq_o=0 next cycle.
- Overflow/write collision:
  - TL=FFFF_FFFF, TCON=3, CPU writes TCON=1 on the overflow edge -> TCON reads 1, irq_o stays 0, TL=32'h1 or 32'h0 per enable?
  - Required: write wins, so TL is not reloaded. TL holds FFFF_FFFF that edge and reloads on the next edge, with no irq because TCON[1]=0.
- Peripherals/unmapped:
  - Write LED=0x1A5 -> led_o=8'hA5.
  - Write DIGI=0xF3F -> digi_o=12'hF3F.
  - Write SYSTICK -> value unchanged, still counting.
  - Load 0x2000_0000 -> 0.
  - MemRead_i=0 -> ReadData_o=0.
- Async reset mid-count:
  - Timer running with irq_o=1; pull reset low between edges.
  - -> irq_o, led_o, digi_o go 0 immediately, without waiting for clk.
  - -> After release, SYSTICK restarts from 0 and RAM still holds prior data.
